// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: steps one full-adder cell over two WIDTH-bit
// operands, LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-2:0] sh_sum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             cell_sum;
    logic             cell_carry;
    logic [WIDTH-1:0] sum_next;

    assign cell_sum   = sh_a[0] ^ sh_b[0] ^ carry;
    assign cell_carry = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);

    // The newest sum bit enters at the MSB; after WIDTH shifts bit 0 lands in place.
    assign sum_next = {cell_sum, sh_sum};

    // NOTE: every register here is updated with <= so all reads in this block
    // see the pre-edge values, exactly like the flops they become.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            sh_sum <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            s      <= '0;
            co     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= ci;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sh_sum <= sum_next[WIDTH-1:1];
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    carry  <= cell_carry;
                    if (cnt == LAST_BIT) begin
                        // s/co are a separate register so partial sums never show.
                        s     <= sum_next;
                        co    <= cell_carry;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
